// File: rtl/stack_ctrl.sv
// Initiator-side sequencer for the return-address stack: turns call/return
// handshakes into stack push/pop commands and tracks occupancy itself.
module stack_ctrl #(
  parameter int width = 8,
  parameter int depth = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             call_req,
  input  logic [width-1:0] call_data,
  input  logic             ret_req,
  input  logic             flush,
  output logic             call_ack,
  output logic             ret_ack,
  output logic [width-1:0] ret_data,
  output logic             err,
  output logic [depth:0]   count,
  output logic             full,
  output logic             empty,
  output logic             stk_en,
  output logic [1:0]       stk_con,
  output logic [width-1:0] stk_data,
  output logic             stk_clr_n,
  input  logic [width-1:0] stk_dout
);

  typedef enum logic [2:0] {
    ST_FLUSH,
    ST_IDLE,
    ST_PUSH,
    ST_POP,
    ST_POP_WAIT,
    ST_DONE
  } state_t;

  localparam logic [1:0]     CON_PUSH   = 2'b00;
  localparam logic [1:0]     CON_POP    = 2'b01;
  localparam logic [1:0]     CON_IDLE   = 2'b10;
  localparam logic [depth:0] FULL_COUNT = {1'b1, {depth{1'b0}}};

  state_t             state_q, state_d;
  logic               call_ack_d, ret_ack_d, err_d;
  logic [width-1:0]   ret_data_d, stk_data_d;
  logic [depth:0]     count_d;
  logic               stk_en_d, stk_clr_n_d;
  logic [1:0]         stk_con_d;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // Next-state and next-output logic; flush overrides whatever is in flight.
  always_comb begin
    state_d     = state_q;
    call_ack_d  = call_ack;
    ret_ack_d   = ret_ack;
    err_d       = err;
    ret_data_d  = ret_data;
    count_d     = count;
    stk_en_d    = 1'b0;
    stk_con_d   = CON_IDLE;
    stk_data_d  = stk_data;
    stk_clr_n_d = 1'b1;

    if (flush) begin
      state_d     = ST_FLUSH;
      call_ack_d  = 1'b0;
      ret_ack_d   = 1'b0;
      err_d       = 1'b0;
      count_d     = '0;
      stk_clr_n_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_FLUSH: begin
          state_d = ST_IDLE;
          count_d = '0;
        end

        ST_IDLE: begin
          if (call_req) begin
            if (!full) begin
              state_d    = ST_PUSH;
              stk_en_d   = 1'b1;
              stk_con_d  = CON_PUSH;
              stk_data_d = call_data;
            end else begin
              state_d    = ST_DONE;
              call_ack_d = 1'b1;
              err_d      = 1'b1;
            end
          end else if (ret_req) begin
            if (!empty) begin
              state_d   = ST_POP;
              stk_en_d  = 1'b1;
              stk_con_d = CON_POP;
            end else begin
              state_d   = ST_DONE;
              ret_ack_d = 1'b1;
              err_d     = 1'b1;
            end
          end
        end

        ST_PUSH: begin
          state_d    = ST_DONE;
          count_d    = count + 1'b1;
          call_ack_d = 1'b1;
          err_d      = 1'b0;
        end

        ST_POP: begin
          state_d = ST_POP_WAIT;
          count_d = count - 1'b1;
        end

        // The stack's data_out is registered, so it is only valid one cycle after the pop.
        ST_POP_WAIT: begin
          state_d    = ST_DONE;
          ret_data_d = stk_dout;
          ret_ack_d  = 1'b1;
          err_d      = 1'b0;
        end

        ST_DONE: begin
          if ((call_ack && !call_req) || (ret_ack && !ret_req) ||
              (!call_ack && !ret_ack)) begin
            state_d    = ST_IDLE;
            call_ack_d = 1'b0;
            ret_ack_d  = 1'b0;
            err_d      = 1'b0;
          end
        end

        default: begin
          state_d     = ST_FLUSH;
          call_ack_d  = 1'b0;
          ret_ack_d   = 1'b0;
          err_d       = 1'b0;
          count_d     = '0;
          stk_clr_n_d = 1'b0;
        end
      endcase
    end
  end

  // Reset lands in FLUSH with the stack clear held so the stack sees it on the first edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= ST_FLUSH;
      call_ack  <= 1'b0;
      ret_ack   <= 1'b0;
      err       <= 1'b0;
      ret_data  <= '0;
      count     <= '0;
      stk_en    <= 1'b0;
      stk_con   <= CON_IDLE;
      stk_data  <= '0;
      stk_clr_n <= 1'b0;
    end else begin
      state_q   <= state_d;
      call_ack  <= call_ack_d;
      ret_ack   <= ret_ack_d;
      err       <= err_d;
      ret_data  <= ret_data_d;
      count     <= count_d;
      stk_en    <= stk_en_d;
      stk_con   <= stk_con_d;
      stk_data  <= stk_data_d;
      stk_clr_n <= stk_clr_n_d;
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl: emulates the registered stack and
// checks every handshake against a queue-based LIFO reference model.
module tb_stack_ctrl;

  localparam int W = 8;
  localparam int D = 3;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         clr;
  logic         call_req, ret_req, flush;
  logic [W-1:0] call_data;
  logic         call_ack, ret_ack, err;
  logic [W-1:0] ret_data;
  logic [D:0]   count;
  logic         full, empty;
  logic         stk_en;
  logic [1:0]   stk_con;
  logic [W-1:0] stk_data;
  logic         stk_clr_n;
  logic [W-1:0] stk_dout;

  int total = 0;
  int bad   = 0;
  int en_cnt = 0;
  int double_en = 0;
  logic prev_en = 1'b0;

  logic [W-1:0] stk_mem[$];
  logic [W-1:0] model[$];
  logic [W-1:0] last_ret = '0;

  stack_ctrl #(.width(W), .depth(D)) dut (
    .clk(clk), .clr(clr),
    .call_req(call_req), .call_data(call_data),
    .ret_req(ret_req), .flush(flush),
    .call_ack(call_ack), .ret_ack(ret_ack), .ret_data(ret_data), .err(err),
    .count(count), .full(full), .empty(empty),
    .stk_en(stk_en), .stk_con(stk_con), .stk_data(stk_data),
    .stk_clr_n(stk_clr_n), .stk_dout(stk_dout)
  );

  always #5 clk = ~clk;

  // Behavioural stack device with a registered data_out and synchronous clear.
  always @(posedge clk) begin
    if (!stk_clr_n) begin
      stk_mem.delete();
      stk_dout <= '0;
    end else if (stk_en && stk_con == 2'b00) begin
      stk_mem.push_back(stk_data);
    end else if (stk_en && stk_con == 2'b01) begin
      if (stk_mem.size() > 0) stk_dout <= stk_mem.pop_back();
      else stk_dout <= '0;
    end
  end

  always @(posedge clk) begin
    if (stk_en) en_cnt++;
    if (stk_en && prev_en) double_en++;
    prev_en = stk_en;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkStatus(input string tag);
    checkOutput({tag, "_count"}, 32'(count), 32'(model.size()));
    checkOutput({tag, "_full"}, 32'(full), 32'(model.size() == N));
    checkOutput({tag, "_empty"}, 32'(empty), 32'(model.size() == 0));
  endtask

  // One complete call (is_ret=0) or return (is_ret=1) handshake, entered just after a falling edge.
  task automatic applyStimulus(input bit is_ret, input logic [W-1:0] data);
    int cycles;
    int en_before;
    bit exp_err;
    logic [W-1:0] exp_data;
    en_before = en_cnt;
    exp_err = is_ret ? (model.size() == 0) : (model.size() == N);
    if (is_ret) ret_req = 1'b1;
    else begin
      call_req  = 1'b1;
      call_data = data;
    end
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!(is_ret ? ret_ack : call_ack) && cycles < 20);
    checkOutput(is_ret ? "ret_ack" : "call_ack", 32'(is_ret ? ret_ack : call_ack), 32'd1);
    checkOutput(is_ret ? "ret_lat" : "call_lat", 32'(cycles - 1),
                exp_err ? 32'd0 : (is_ret ? 32'd2 : 32'd1));
    checkOutput(is_ret ? "ret_err" : "call_err", 32'(err), 32'(exp_err));
    if (is_ret) begin
      exp_data = exp_err ? last_ret : model.pop_back();
      last_ret = exp_data;
      checkOutput("ret_data", 32'(ret_data), 32'(exp_data));
    end else if (!exp_err) begin
      model.push_back(data);
    end
    checkStatus(is_ret ? "ret" : "call");
    checkOutput("stk_en_pulses", 32'(en_cnt - en_before), exp_err ? 32'd0 : 32'd1);
    call_req = 1'b0;
    ret_req  = 1'b0;
    @(negedge clk);
    checkOutput("ack_drop", 32'({call_ack, ret_ack, err}), 32'd0);
  endtask

  task automatic doFlush();
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_clr_n", 32'(stk_clr_n), 32'd0);
    checkOutput("flush_acks", 32'({call_ack, ret_ack, err}), 32'd0);
    model.delete();
    checkStatus("flush");
    flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_release", 32'(stk_clr_n), 32'd1);
  endtask

  initial begin
    int cycles;
    int r;
    clr = 1'b1;
    call_req = 1'b0;
    ret_req = 1'b0;
    flush = 1'b0;
    call_data = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_clr_n", 32'(stk_clr_n), 32'd0);
    checkOutput("rst_en", 32'(stk_en), 32'd0);
    checkOutput("rst_con", 32'(stk_con), 32'd2);
    checkOutput("rst_stk_data", 32'(stk_data), 32'd0);
    checkOutput("rst_acks", 32'({call_ack, ret_ack, err}), 32'd0);
    checkOutput("rst_ret_data", 32'(ret_data), 32'd0);
    checkStatus("rst");

    clr = 1'b0;
    #1;
    checkOutput("rel_clr_n_low", 32'(stk_clr_n), 32'd0);
    @(negedge clk);
    checkOutput("rel_clr_n_high", 32'(stk_clr_n), 32'd1);
    checkOutput("rel_con", 32'(stk_con), 32'd2);
    checkOutput("rel_acks", 32'({call_ack, ret_ack}), 32'd0);
    checkStatus("rel");

    $display("[TB] push 11/22/33 then pop three times");
    applyStimulus(1'b0, 8'h11);
    applyStimulus(1'b0, 8'h22);
    applyStimulus(1'b0, 8'h33);
    repeat (3) applyStimulus(1'b1, '0);

    $display("[TB] fill to full then overflow");
    repeat (N) applyStimulus(1'b0, 8'($urandom));
    applyStimulus(1'b0, 8'hEE);

    $display("[TB] flush then underflow");
    doFlush();
    applyStimulus(1'b1, '0);

    $display("[TB] flush during POP_WAIT");
    applyStimulus(1'b0, 8'hA1);
    applyStimulus(1'b0, 8'hA2);
    ret_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    checkOutput("pw_flush_ret_ack", 32'(ret_ack), 32'd0);
    checkOutput("pw_flush_clr_n", 32'(stk_clr_n), 32'd0);
    checkOutput("pw_flush_count", 32'(count), 32'd0);
    model.delete();
    flush = 1'b0;
    ret_req = 1'b0;
    @(negedge clk);
    checkOutput("pw_flush_release", 32'(stk_clr_n), 32'd1);
    checkOutput("pw_flush_no_ack", 32'(ret_ack), 32'd0);
    applyStimulus(1'b1, '0);

    $display("[TB] simultaneous call and return");
    applyStimulus(1'b0, 8'hB1);
    applyStimulus(1'b0, 8'hB2);
    call_req = 1'b1;
    ret_req = 1'b1;
    call_data = 8'h5A;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!call_ack && cycles < 20);
    checkOutput("both_call_first", 32'({call_ack, ret_ack, err}), 32'b100);
    checkOutput("both_call_lat", 32'(cycles - 1), 32'd1);
    model.push_back(8'h5A);
    checkStatus("both_call");
    call_req = 1'b0;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!ret_ack && cycles < 20);
    checkOutput("both_ret_ack", 32'({ret_ack, err}), 32'b10);
    last_ret = model.pop_back();
    checkOutput("both_ret_data", 32'(ret_data), 32'(last_ret));
    checkStatus("both_ret");
    ret_req = 1'b0;
    @(negedge clk);
    checkOutput("both_ack_drop", 32'(ret_ack), 32'd0);

    $display("[TB] randomized operations");
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 11));
      if (r == 0) doFlush();
      else if (r <= 6) applyStimulus(1'b0, 8'($urandom));
      else applyStimulus(1'b1, '0);
    end

    checkOutput("stk_en_back_to_back", 32'(double_en), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
